// File: rtl/ejtag_drseg_ctl_pkg.sv
// Shared constants, state encodings and request classification for the
// drseg access sequencer in front of the data-breakpoint unit.
package ejtag_drseg_ctl_pkg;

    localparam int unsigned DRSEG_AW = 14;
    localparam int unsigned OFF_W    = 16;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned EJ_AW    = 6;

    localparam logic [15:0] OFF_DBS        = 16'h2000;
    localparam logic [15:0] OFF_BRK_BASE   = 16'h2100;
    localparam logic [15:0] OFF_BRK_STRIDE = 16'h0100;
    localparam int unsigned BRK_SH         = $clog2(OFF_BRK_STRIDE);

    localparam logic [7:0] ROFF_DBA = 8'h00;
    localparam logic [7:0] ROFF_DBM = 8'h08;
    localparam logic [7:0] ROFF_DBC = 8'h18;
    localparam logic [7:0] ROFF_DBV = 8'h20;

    localparam logic [1:0] RC_DBA = 2'b00;
    localparam logic [1:0] RC_DBC = 2'b01;
    localparam logic [1:0] RC_DBM = 2'b10;
    localparam logic [1:0] RC_DBV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CL_LEGAL = 2'd0,
        CL_NULL  = 2'd1,
        CL_ERROR = 2'd2
    } cls_e;

    // Debug mode is checked first so a non-debug access always errors.
    function automatic cls_e classify(input logic dm, input logic mapped,
                                      input logic rd, input logic [3:0] be);
        cls_e c;
        c = CL_LEGAL;
        if (!dm)
            c = CL_ERROR;
        else if (!mapped)
            c = CL_NULL;
        else if (!rd && (be != 4'hF))
            c = CL_NULL;
        return c;
    endfunction

endpackage

// File: rtl/ejtag_drseg_ctl_if.sv
// Core-side drseg request/acknowledge bus.
interface ejtag_drseg_ctl_if;
    import ejtag_drseg_ctl_pkg::*;

    logic                DRSEG_REQ;
    logic                DRSEG_RW;
    logic [DRSEG_AW-1:0] DRSEG_ADDR;
    logic [3:0]          DRSEG_BE;
    logic [DATA_W-1:0]   DRSEG_WDATA;
    logic                DRSEG_ACK;
    logic [DATA_W-1:0]   DRSEG_RDATA;
    logic                DRSEG_ERR;

    modport master (
        output DRSEG_REQ, DRSEG_RW, DRSEG_ADDR, DRSEG_BE, DRSEG_WDATA,
        input  DRSEG_ACK, DRSEG_RDATA, DRSEG_ERR
    );

    modport slave (
        input  DRSEG_REQ, DRSEG_RW, DRSEG_ADDR, DRSEG_BE, DRSEG_WDATA,
        output DRSEG_ACK, DRSEG_RDATA, DRSEG_ERR
    );

endinterface

// File: rtl/ejtag_drseg_decode.sv
// Maps a drseg byte offset onto the compact breakpoint register address.
module ejtag_drseg_decode
    import ejtag_drseg_ctl_pkg::*;
#(
    parameter int unsigned NDBRK = 2
) (
    input  logic [OFF_W-1:0] i_offset,
    output logic             o_sel_dbs,
    output logic             o_sel_dbrs,
    output logic [EJ_AW-1:0] o_ejdi_addr,
    output logic             o_mapped
);

    logic [OFF_W-1:0] w_rel;
    logic [7:0]       w_idx;
    logic [1:0]       w_rc;
    logic             w_rhit;
    logic             w_in_range;

    always_comb begin
        o_sel_dbs   = 1'b0;
        o_sel_dbrs  = 1'b0;
        o_ejdi_addr = '0;
        o_mapped    = 1'b0;
        w_rc        = RC_DBA;
        w_rhit      = 1'b1;

        w_rel      = i_offset - OFF_BRK_BASE;
        w_idx      = 8'(w_rel >> BRK_SH);
        w_in_range = (i_offset >= OFF_BRK_BASE) && (w_idx < 8'(NDBRK));

        unique case (w_rel[7:0])
            ROFF_DBA: w_rc = RC_DBA;
            ROFF_DBC: w_rc = RC_DBC;
            ROFF_DBM: w_rc = RC_DBM;
            ROFF_DBV: w_rc = RC_DBV;
            default:  w_rhit = 1'b0;
        endcase

        if (i_offset == OFF_DBS) begin
            o_sel_dbs = 1'b1;
            o_mapped  = 1'b1;
        end else if (w_in_range && w_rhit) begin
            o_sel_dbrs  = 1'b1;
            o_mapped    = 1'b1;
            o_ejdi_addr = {w_idx[3:0], w_rc};
        end
    end

endmodule

// File: rtl/ejtag_drseg_ctl.sv
// drseg access sequencer: filters illegal requests, issues one strobe per
// legal access to the breakpoint unit and returns a one-cycle acknowledge.
module ejtag_drseg_ctl
    import ejtag_drseg_ctl_pkg::*;
#(
    parameter int unsigned NDBRK = 2
) (
    input  logic                CORE_CLOCK,
    input  logic                RESET_D1_R_N,
    input  logic                CP0_DM,
    ejtag_drseg_ctl_if.slave    drseg,
    output logic [DATA_W-1:0]   EJDI_DATA,
    output logic [EJ_AW-1:0]    EJDI_ADDR,
    output logic                EJDI_RW,
    output logic                EJ_STROBE,
    output logic                EJDI_SELDBS,
    output logic                EJDI_SELDBRS,
    input  logic [DATA_W-1:0]   EJDM_DATA
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [OFF_W-1:0]  w_offset;
    logic              w_sel_dbs;
    logic              w_sel_dbrs;
    logic [EJ_AW-1:0]  w_dec_addr;
    logic              w_mapped;
    cls_e              w_cls;
    logic              w_accept;
    logic              w_go_access;

    logic              r_ack;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;
    logic              r_strobe;
    logic              r_sel_dbs;
    logic              r_sel_dbrs;
    logic [EJ_AW-1:0]  r_addr;
    logic              r_rw;
    logic [DATA_W-1:0] r_wdata;

    assign w_offset = {drseg.DRSEG_ADDR, 2'b00};

    ejtag_drseg_decode #(.NDBRK(NDBRK)) u_decode (
        .i_offset    (w_offset),
        .o_sel_dbs   (w_sel_dbs),
        .o_sel_dbrs  (w_sel_dbrs),
        .o_ejdi_addr (w_dec_addr),
        .o_mapped    (w_mapped)
    );

    assign w_cls       = classify(CP0_DM, w_mapped, drseg.DRSEG_RW, drseg.DRSEG_BE);
    assign w_accept    = (r_state == ST_IDLE) && drseg.DRSEG_REQ;
    assign w_go_access = (w_state_nxt == ST_ACCESS);

    always_ff @(posedge CORE_CLOCK) begin
        if (!RESET_D1_R_N)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Filtered requests skip ACCESS so the breakpoint unit never sees them.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (drseg.DRSEG_REQ)
                           w_state_nxt = (w_cls == CL_LEGAL) ? ST_ACCESS : ST_RESP;
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Strobe/selects/ack are registered from the next state so they are glitch-free.
    always_ff @(posedge CORE_CLOCK) begin
        if (!RESET_D1_R_N) begin
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_strobe   <= 1'b0;
            r_sel_dbs  <= 1'b0;
            r_sel_dbrs <= 1'b0;
            r_addr     <= '0;
            r_rw       <= 1'b1;
            r_wdata    <= '0;
        end else begin
            r_ack      <= (w_state_nxt == ST_RESP);
            r_err      <= w_accept && (w_cls == CL_ERROR);
            r_strobe   <= w_go_access;
            r_sel_dbs  <= w_go_access && w_sel_dbs;
            r_sel_dbrs <= w_go_access && w_sel_dbrs;
            r_rdata    <= ((r_state == ST_ACCESS) && r_rw) ? EJDM_DATA : '0;
            if (w_accept) begin
                r_addr  <= w_dec_addr;
                r_rw    <= drseg.DRSEG_RW;
                r_wdata <= drseg.DRSEG_WDATA;
            end
        end
    end

    assign drseg.DRSEG_ACK   = r_ack;
    assign drseg.DRSEG_ERR   = r_err;
    assign drseg.DRSEG_RDATA = r_rdata;
    assign EJ_STROBE         = r_strobe;
    assign EJDI_SELDBS       = r_sel_dbs;
    assign EJDI_SELDBRS      = r_sel_dbrs;
    assign EJDI_ADDR         = r_addr;
    assign EJDI_RW           = r_rw;
    assign EJDI_DATA         = r_wdata;

endmodule
